// File: rtl/issue_select_if.sv
// Issue-select bundle: allocation/ready inputs, payload read ports and two registered ALU issue packets.
interface issue_select_if #(
  parameter int RS_DEPTH = 8,
  parameter int RS_IDX_W = $clog2(RS_DEPTH),
  parameter int TAG_W    = 6,
  parameter int DATA_W   = 32
);
  logic                flush;
  logic [RS_DEPTH-1:0] entry_wen;
  logic [RS_DEPTH-1:0] ready_mask;
  logic [RS_IDX_W-1:0] sel_idx_0, sel_idx_1;
  logic [RS_DEPTH-1:0] issue_grant;

  logic [31:0]         rs_op_0, rs_op_1;
  logic [TAG_W-1:0]    rs_dst_tag_0, rs_dst_tag_1;
  logic [DATA_W-1:0]   rs_v1_0, rs_v1_1, rs_v2_0, rs_v2_1;

  logic                alu_valid_0, alu_valid_1;
  logic [31:0]         alu_op_0, alu_op_1;
  logic [TAG_W-1:0]    alu_dst_tag_0, alu_dst_tag_1;
  logic [DATA_W-1:0]   alu_v1_0, alu_v1_1, alu_v2_0, alu_v2_1;
  logic                alu_ready_0, alu_ready_1;

  modport slave (
    input  flush, entry_wen, ready_mask,
    input  rs_op_0, rs_op_1, rs_dst_tag_0, rs_dst_tag_1,
    input  rs_v1_0, rs_v1_1, rs_v2_0, rs_v2_1,
    input  alu_ready_0, alu_ready_1,
    output sel_idx_0, sel_idx_1, issue_grant,
    output alu_valid_0, alu_valid_1, alu_op_0, alu_op_1,
    output alu_dst_tag_0, alu_dst_tag_1, alu_v1_0, alu_v1_1, alu_v2_0, alu_v2_1
  );

  modport master (
    output flush, entry_wen, ready_mask,
    output rs_op_0, rs_op_1, rs_dst_tag_0, rs_dst_tag_1,
    output rs_v1_0, rs_v1_1, rs_v2_0, rs_v2_1,
    output alu_ready_0, alu_ready_1,
    input  sel_idx_0, sel_idx_1, issue_grant,
    input  alu_valid_0, alu_valid_1, alu_op_0, alu_op_1,
    input  alu_dst_tag_0, alu_dst_tag_1, alu_v1_0, alu_v1_1, alu_v2_0, alu_v2_1
  );
endinterface

// File: rtl/issue_select.sv
// Two-wide reservation-station issue select feeding two registered ALU issue slots.
// ISSUE_AGE_ORDER_EN: oldest-first selection via an age matrix; otherwise lowest-index-first.
module issue_slot #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              grant,
  input  logic              alu_ready,
  input  logic [31:0]       rs_op,
  input  logic [TAG_W-1:0]  rs_dst_tag,
  input  logic [DATA_W-1:0] rs_v1,
  input  logic [DATA_W-1:0] rs_v2,
  output logic              can_accept,
  output logic              alu_valid,
  output logic [31:0]       alu_op,
  output logic [TAG_W-1:0]  alu_dst_tag,
  output logic [DATA_W-1:0] alu_v1,
  output logic [DATA_W-1:0] alu_v2
);
  typedef struct packed {
    logic [31:0]       op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
  } pkt_t;

  pkt_t pkt_d, pkt_q;
  logic valid_d, valid_q;

  assign can_accept = !valid_q || alu_ready;

  // grant is only raised when can_accept, so loading never overwrites a stalled packet
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (grant) begin
      valid_d = 1'b1;
      pkt_d   = '{op: rs_op, tag: rs_dst_tag, v1: rs_v1, v2: rs_v2};
    end else if (alu_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign alu_valid   = valid_q;
  assign alu_op      = pkt_q.op;
  assign alu_dst_tag = pkt_q.tag;
  assign alu_v1      = pkt_q.v1;
  assign alu_v2      = pkt_q.v2;
endmodule

module issue_select #(
  parameter int RS_DEPTH = 8,
  parameter int RS_IDX_W = $clog2(RS_DEPTH),
  parameter int TAG_W    = 6,
  parameter int DATA_W   = 32
) (
  input logic         clk,
  input logic         rst_n,
  issue_select_if.slave io
);
  localparam int NUM_CH = 2;

  logic [RS_DEPTH-1:0] cand_0, cand_1, old_0, old_1, pick_0, pick_1;
  logic [NUM_CH-1:0]   acc, grant_ch, alu_ready_ch, alu_valid_ch;
  logic [NUM_CH-1:0][31:0]       rs_op, alu_op;
  logic [NUM_CH-1:0][TAG_W-1:0]  rs_tag, alu_tag;
  logic [NUM_CH-1:0][DATA_W-1:0] rs_v1, rs_v2, alu_v1, alu_v2;

  function automatic logic [RS_DEPTH-1:0] lowest_one(input logic [RS_DEPTH-1:0] m);
    lowest_one = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_one    = '0;
        lowest_one[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [RS_IDX_W-1:0] idx_of(input logic [RS_DEPTH-1:0] oh);
    idx_of = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (oh[i]) idx_of = RS_IDX_W'(i);
    end
  endfunction

`ifdef ISSUE_AGE_ORDER_EN
  // older_q[i][j]: entry i was allocated before entry j
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_d, older_q;

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (i != j) begin
          if (io.entry_wen[i] && io.entry_wen[j]) older_d[i][j] = (i < j);
          else if (io.entry_wen[i])               older_d[i][j] = 1'b0;
          else if (io.entry_wen[j])               older_d[i][j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) older_q <= '0;
    else        older_q <= older_d;
  end
`else
  logic unused_wen;
  assign unused_wen = ^io.entry_wen;
`endif

  // A stalled slot 0 opts out, so channel 1 then sees the full candidate set
  always_comb begin
    cand_0 = acc[0] ? io.ready_mask : '0;
    old_0  = cand_0;
`ifdef ISSUE_AGE_ORDER_EN
    for (int i = 0; i < RS_DEPTH; i++)
      for (int j = 0; j < RS_DEPTH; j++)
        if (cand_0[j] && older_q[j][i]) old_0[i] = 1'b0;
`endif
    pick_0 = lowest_one(old_0);
    cand_1 = io.ready_mask & ~pick_0;
    old_1  = cand_1;
`ifdef ISSUE_AGE_ORDER_EN
    for (int i = 0; i < RS_DEPTH; i++)
      for (int j = 0; j < RS_DEPTH; j++)
        if (cand_1[j] && older_q[j][i]) old_1[i] = 1'b0;
`endif
    pick_1 = lowest_one(old_1);
  end

  assign grant_ch[0] = (|pick_0) && acc[0] && !io.flush && rst_n;
  assign grant_ch[1] = (|pick_1) && acc[1] && !io.flush && rst_n;

  assign io.issue_grant = (grant_ch[0] ? pick_0 : '0) | (grant_ch[1] ? pick_1 : '0);
  assign io.sel_idx_0   = idx_of(pick_0);
  assign io.sel_idx_1   = idx_of(pick_1);

  assign alu_ready_ch = {io.alu_ready_1, io.alu_ready_0};
  assign rs_op        = {io.rs_op_1, io.rs_op_0};
  assign rs_tag       = {io.rs_dst_tag_1, io.rs_dst_tag_0};
  assign rs_v1        = {io.rs_v1_1, io.rs_v1_0};
  assign rs_v2        = {io.rs_v2_1, io.rs_v2_0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    issue_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (io.flush),
      .grant       (grant_ch[g]),
      .alu_ready   (alu_ready_ch[g]),
      .rs_op       (rs_op[g]),
      .rs_dst_tag  (rs_tag[g]),
      .rs_v1       (rs_v1[g]),
      .rs_v2       (rs_v2[g]),
      .can_accept  (acc[g]),
      .alu_valid   (alu_valid_ch[g]),
      .alu_op      (alu_op[g]),
      .alu_dst_tag (alu_tag[g]),
      .alu_v1      (alu_v1[g]),
      .alu_v2      (alu_v2[g])
    );
  end

  assign io.alu_valid_0   = alu_valid_ch[0];
  assign io.alu_valid_1   = alu_valid_ch[1];
  assign io.alu_op_0      = alu_op[0];
  assign io.alu_op_1      = alu_op[1];
  assign io.alu_dst_tag_0 = alu_tag[0];
  assign io.alu_dst_tag_1 = alu_tag[1];
  assign io.alu_v1_0      = alu_v1[0];
  assign io.alu_v1_1      = alu_v1[1];
  assign io.alu_v2_0      = alu_v2[0];
  assign io.alu_v2_1      = alu_v2[1];
endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select; expectations follow the build's selection order.
module tb_issue_select;
`ifdef ISSUE_AGE_ORDER_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  issue_select_if #(.RS_DEPTH(8), .RS_IDX_W(3), .TAG_W(6), .DATA_W(32)) io ();

  issue_select #(.RS_DEPTH(8), .RS_IDX_W(3), .TAG_W(6), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  // RS storage model: payload of entry i is a fixed function of i
  function automatic logic [31:0] e_op(input int i);  return 32'h0C00_0000 + i; endfunction
  function automatic logic [5:0]  e_tag(input int i); return 6'(16 + i);        endfunction
  function automatic logic [31:0] e_v1(input int i);  return 32'h1111_0000 + i; endfunction
  function automatic logic [31:0] e_v2(input int i);  return 32'h2222_0000 + i; endfunction

  assign io.rs_op_0      = e_op(int'(io.sel_idx_0));
  assign io.rs_op_1      = e_op(int'(io.sel_idx_1));
  assign io.rs_dst_tag_0 = e_tag(int'(io.sel_idx_0));
  assign io.rs_dst_tag_1 = e_tag(int'(io.sel_idx_1));
  assign io.rs_v1_0      = e_v1(int'(io.sel_idx_0));
  assign io.rs_v1_1      = e_v1(int'(io.sel_idx_1));
  assign io.rs_v2_0      = e_v2(int'(io.sel_idx_0));
  assign io.rs_v2_1      = e_v2(int'(io.sel_idx_1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] wen, input logic [7:0] rdy,
                       input logic r0, input logic r1, input logic fl);
    io.entry_wen   = wen;
    io.ready_mask  = rdy;
    io.alu_ready_0 = r0;
    io.alu_ready_1 = r1;
    io.flush       = fl;
    #1;
  endtask

  task automatic chk_slot0(input string tag, input int e);
    chk({tag, "_v0"},   64'(io.alu_valid_0),   64'd1);
    chk({tag, "_op0"},  64'(io.alu_op_0),      64'(e_op(e)));
    chk({tag, "_tag0"}, 64'(io.alu_dst_tag_0), 64'(e_tag(e)));
    chk({tag, "_v1_0"}, 64'(io.alu_v1_0),      64'(e_v1(e)));
    chk({tag, "_v2_0"}, 64'(io.alu_v2_0),      64'(e_v2(e)));
  endtask

  task automatic chk_slot1(input string tag, input int e);
    chk({tag, "_v1"},   64'(io.alu_valid_1),   64'd1);
    chk({tag, "_op1"},  64'(io.alu_op_1),      64'(e_op(e)));
    chk({tag, "_tag1"}, 64'(io.alu_dst_tag_1), 64'(e_tag(e)));
    chk({tag, "_v1_1"}, 64'(io.alu_v1_1),      64'(e_v1(e)));
    chk({tag, "_v2_1"}, 64'(io.alu_v2_1),      64'(e_v2(e)));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("rst_grant", 64'(io.issue_grant), 64'h0);
    tick();
    tick();
    chk("rst_v0",  64'(io.alu_valid_0), 64'd0);
    chk("rst_v1",  64'(io.alu_valid_1), 64'd0);
    chk("rst_op0", 64'(io.alu_op_0),    64'd0);
    chk("rst_v2_1", 64'(io.alu_v2_1),   64'd0);

    // idle after reset
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("idle_grant", 64'(io.issue_grant), 64'h0);
    chk("idle_sel0",  64'(io.sel_idx_0),   64'd0);
    chk("idle_sel1",  64'(io.sel_idx_1),   64'd0);
    tick();
    chk("idle_v0", 64'(io.alu_valid_0), 64'd0);
    chk("idle_v1", 64'(io.alu_valid_1), 64'd0);

    // allocate 5, 2, 7 in successive cycles
    drive(8'h20, 8'h00, 1'b1, 1'b1, 1'b0); tick();
    drive(8'h04, 8'h00, 1'b1, 1'b1, 1'b0); tick();
    drive(8'h80, 8'h00, 1'b1, 1'b1, 1'b0); tick();
    drive(8'h00, 8'hA4, 1'b1, 1'b1, 1'b0);
    chk("a3_grant", 64'(io.issue_grant), 64'h24);
    chk("a3_sel0",  64'(io.sel_idx_0),   AGE ? 64'd5 : 64'd2);
    chk("a3_sel1",  64'(io.sel_idx_1),   AGE ? 64'd2 : 64'd5);
    tick();
    chk_slot0("a3", AGE ? 5 : 2);
    chk_slot1("a3", AGE ? 2 : 5);

    // allocate 3 and 1 together; lower index is older
    drive(8'h0A, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    chk("drain_v0", 64'(io.alu_valid_0), 64'd0);
    drive(8'h00, 8'h0A, 1'b1, 1'b1, 1'b0);
    chk("pair_grant", 64'(io.issue_grant), 64'h0A);
    chk("pair_sel0",  64'(io.sel_idx_0),   64'd1);
    chk("pair_sel1",  64'(io.sel_idx_1),   64'd3);
    tick();
    chk_slot0("pair", 1);
    chk_slot1("pair", 3);

    // stall slot 0, drain slot 1
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk_slot0("hold", 1);
    chk("hold_v1", 64'(io.alu_valid_1), 64'd0);

    // slot 0 stalled: single candidate goes out on channel 1
    drive(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("ch1_grant", 64'(io.issue_grant), 64'h01);
    chk("ch1_sel0",  64'(io.sel_idx_0),   64'd0);
    chk("ch1_sel1",  64'(io.sel_idx_1),   64'd0);
    tick();
    chk_slot0("ch1", 1);
    chk_slot1("ch1", 0);

    // both slots stalled: nothing granted
    drive(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("stall_grant", 64'(io.issue_grant), 64'h0);
    tick();
    chk_slot0("stall", 1);
    chk_slot1("stall", 0);

    // flush kills grant and clears held packets
    drive(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    chk("flush_grant", 64'(io.issue_grant), 64'h0);
    tick();
    chk("flush_v0", 64'(io.alu_valid_0), 64'd0);
    chk("flush_v1", 64'(io.alu_valid_1), 64'd0);

    // age order survives flush
    drive(8'h00, 8'hA4, 1'b1, 1'b1, 1'b0);
    chk("pf_grant", 64'(io.issue_grant), 64'h24);
    chk("pf_sel0",  64'(io.sel_idx_0),   AGE ? 64'd5 : 64'd2);
    chk("pf_sel1",  64'(io.sel_idx_1),   AGE ? 64'd2 : 64'd5);
    tick();

    // single candidate on channel 0 only; slot 1 clears on accept
    drive(8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
    chk("one_grant", 64'(io.issue_grant), 64'h80);
    chk("one_sel0",  64'(io.sel_idx_0),   64'd7);
    chk("one_sel1",  64'(io.sel_idx_1),   64'd0);
    tick();
    chk_slot0("one", 7);
    chk("one_v1", 64'(io.alu_valid_1), 64'd0);

    // allocate 6 then 1
    drive(8'h40, 8'h00, 1'b1, 1'b1, 1'b0); tick();
    drive(8'h02, 8'h00, 1'b1, 1'b1, 1'b0); tick();
    drive(8'h00, 8'h42, 1'b1, 1'b1, 1'b0);
    chk("r61_grant", 64'(io.issue_grant), 64'h42);
    chk("r61_sel0",  64'(io.sel_idx_0),   AGE ? 64'd6 : 64'd1);
    chk("r61_sel1",  64'(io.sel_idx_1),   AGE ? 64'd1 : 64'd6);
    tick();
    chk_slot0("r61", AGE ? 6 : 1);
    chk_slot1("r61", AGE ? 1 : 6);

    // reset mid-stall drops held packets and the age order
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_slot0("ms", AGE ? 6 : 1);
    rst_n = 1'b0;
    drive(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("ms_grant", 64'(io.issue_grant), 64'h0);
    tick();
    chk("ms_v0",  64'(io.alu_valid_0), 64'd0);
    chk("ms_v1",  64'(io.alu_valid_1), 64'd0);
    chk("ms_op0", 64'(io.alu_op_0),    64'd0);
    rst_n = 1'b1;
    drive(8'h00, 8'h42, 1'b1, 1'b1, 1'b0);
    chk("post_sel0", 64'(io.sel_idx_0), 64'd1);
    chk("post_sel1", 64'(io.sel_idx_1), 64'd6);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 8, number of reservation-station entries.
REQ-002 SHALL have parameter RS_IDX_W, default $clog2(RS_DEPTH), entry index width.
REQ-003 SHALL have parameters TAG_W, default 6, and DATA_W, default 32: tag and operand widths.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: flush  in  1  kill in-flight issue; entry_wen  in  RS_DEPTH  entries allocated this cycle; ready_mask  in  RS_DEPTH  entries with both operands ready.
REQ-006 SHALL have ports: sel_idx_0, sel_idx_1  out  RS_IDX_W  read index per ALU channel; issue_grant  out  RS_DEPTH  one-hot-or-two-hot entries released this cycle.
REQ-007 SHALL have ports: rs_op_k  in  32; rs_dst_tag_k  in  TAG_W; rs_v1_k, rs_v2_k  in  DATA_W; entry payload read at sel_idx_k, k in {0,1}.
REQ-008 SHALL have ports: alu_valid_k  out  1; alu_op_k  out  32; alu_dst_tag_k  out  TAG_W; alu_v1_k, alu_v2_k  out  DATA_W; alu_ready_k  in  1; registered issue packet per ALU k.

Function
REQ-009 SHALL keep an RS_DEPTH x RS_DEPTH age matrix; older[i][j]=1 means entry i allocated before entry j.
REQ-010 On entry_wen[i], SHALL set older[j][i]=1 and older[i][j]=0 for all j not allocated this cycle; among entries allocated in the same cycle, the lower index is older.
REQ-011 Candidate set = ready_mask; slot k "can accept" when alu_valid_k=0 or alu_ready_k=1.
REQ-012 Channel 0 SHALL pick the oldest candidate (no candidate older than it); channel 1 SHALL pick the oldest candidate excluding channel 0's pick.
REQ-013 If slot 0 cannot accept, channel 1 SHALL still pick the oldest candidate; a stalled channel SHALL not grant.
REQ-014 issue_grant[i] SHALL be 1 only for an entry picked by a channel that can accept, and 0 for all entries when flush=1.
REQ-015 sel_idx_k SHALL equal the picked index, combinationally, or 0 when channel k picks nothing.
REQ-016 On grant at cycle N, alu_*_k SHALL hold rs_*_k sampled at N and alu_valid_k=1 from cycle N+1 (latency one cycle).
REQ-017 Slot k SHALL hold its packet unchanged while alu_valid_k=1 and alu_ready_k=0; on accept without a new grant, alu_valid_k SHALL clear next cycle.
REQ-018 flush SHALL clear both alu_valid_k next cycle regardless of alu_ready_k; age matrix unaffected.
REQ-019 Empty candidate set SHALL produce issue_grant=0; single candidate SHALL go to channel 0 only.
REQ-020 An entry SHALL never be granted twice in one cycle.

Reset
REQ-021 While rst_n=0 at a clk edge: alu_valid_0/1=0, alu payload registers=0, age matrix all 0.
REQ-022 issue_grant SHALL be 0 during any cycle rst_n=0; reset mid-stall SHALL drop the held packets.

Configuration
REQ-023 Macro ISSUE_AGE_ORDER_EN: when defined, selection per REQ-009..REQ-012.
REQ-024 When ISSUE_AGE_ORDER_EN is undefined, age matrix SHALL be omitted; channel 0 picks the lowest ready index, channel 1 the next-lowest; all other requirements unchanged.

Verification
REQ-025 Reset, then ready_mask=0 -> issue_grant=0, alu_valid_0/1=0, sel_idx_0/1=0.
REQ-026 Allocate entries 5, then 2, then 7 in successive cycles, ready_mask=8'hA4, both ALUs ready -> grant=8'h24, sel_idx_0=5, sel_idx_1=2; next cycle alu_valid_0/1=1 with entry 5/2 payloads.
REQ-027 Allocate entries 3 and 1 in one cycle, ready_mask=8'h0A -> sel_idx_0=1, sel_idx_1=3 (lower index older).
REQ-028 alu_valid_0=1, alu_ready_0=0, alu_ready_1=1, ready_mask=8'h01 -> issue_grant=8'h01 via channel 1; alu_*_0 unchanged.
REQ-029 flush=1 with ready_mask=8'hFF and valid packets -> issue_grant=0; alu_valid_0/1=0 next cycle.
REQ-030 Build without ISSUE_AGE_ORDER_EN, allocate 6 then 1, ready_mask=8'h42 -> sel_idx_0=1, sel_idx_1=6.
